// File: rtl/hovalaag_io_port.sv
// Host-side I/O harness for the Hovalaag CPU data ports.
// Two host-filled input FIFOs feed the CPU IN ports; two output FIFOs
// capture CPU results for the host. Sticky flags record CPU reads from
// an empty input and CPU writes to a full output (the CPU cannot stall).

module hovalaag_fifo #(
    parameter int DEPTH  = 16,
    parameter int CW     = $clog2(DEPTH) + 1,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic [CW-1:0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Pointer and occupancy bookkeeping; wr/rd arrive already qualified.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{(CW-1){1'b0}}, wr} - {{(CW-1){1'b0}}, rd};
        end
    end

    // Storage is data only, so it is not reset; the pointers make it invisible.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];
endmodule

module hovalaag_io_port #(
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          host_wr_en,
    input  logic          host_wr_sel,
    input  logic [11:0]   host_wr_data,
    output logic          host_wr_ready,
    input  logic          host_rd_en,
    input  logic          host_rd_sel,
    output logic [11:0]   host_rd_data,
    output logic          host_rd_valid,
    output logic [CW-1:0] in1_count,
    output logic [CW-1:0] in2_count,
    output logic [CW-1:0] out1_count,
    output logic [CW-1:0] out2_count,
    output logic [11:0]   cpu_in1,
    output logic [11:0]   cpu_in2,
    input  logic          cpu_in1_adv,
    input  logic          cpu_in2_adv,
    input  logic [11:0]   cpu_out,
    input  logic          cpu_out_valid,
    input  logic          cpu_out_select,
    output logic [1:0]    underflow,
    output logic [1:0]    overflow,
    input  logic          clr_status
);
    localparam int DATA_W = 12;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [1:0]        in_adv;
    logic [1:0]        in_push;
    logic [1:0]        in_pop;
    logic [1:0]        uf_set;
    logic [DATA_W-1:0] in_head [2];
    logic [CW-1:0]     in_cnt  [2];

    logic [1:0]        out_cap;
    logic [1:0]        out_rd;
    logic [1:0]        of_set;
    logic [DATA_W-1:0] out_head [2];
    logic [CW-1:0]     out_cnt  [2];

    assign in_adv = {cpu_in2_adv, cpu_in1_adv};

    for (genvar i = 0; i < 2; i++) begin : g_in
        // Push is judged on the pre-edge count, so a full FIFO rejects it even
        // when a same-edge pop would have freed a slot.
        assign in_push[i] = host_wr_en && (host_wr_sel == 1'(i)) && (in_cnt[i] != FULL_CNT);
        assign in_pop[i]  = in_adv[i] && (in_cnt[i] != '0);
        assign uf_set[i]  = in_adv[i] && (in_cnt[i] == '0);

        hovalaag_fifo #(.DEPTH(DEPTH), .CW(CW), .DATA_W(DATA_W)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr    (in_push[i]),
            .rd    (in_pop[i]),
            .wdata (host_wr_data),
            .head  (in_head[i]),
            .count (in_cnt[i])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_out
        // A host read of a full FIFO frees the slot for a same-edge capture.
        assign out_rd[i]  = host_rd_en && (host_rd_sel == 1'(i)) && (out_cnt[i] != '0);
        assign out_cap[i] = cpu_out_valid && (cpu_out_select == 1'(i))
                            && ((out_cnt[i] != FULL_CNT) || out_rd[i]);
        assign of_set[i]  = cpu_out_valid && (cpu_out_select == 1'(i)) && !out_cap[i];

        hovalaag_fifo #(.DEPTH(DEPTH), .CW(CW), .DATA_W(DATA_W)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr    (out_cap[i]),
            .rd    (out_rd[i]),
            .wdata (cpu_out),
            .head  (out_head[i]),
            .count (out_cnt[i])
        );
    end

    // Zero-latency head: the CPU samples IN on the same edge it asserts adv.
    assign cpu_in1       = (in_cnt[0] == '0) ? '0 : in_head[0];
    assign cpu_in2       = (in_cnt[1] == '0) ? '0 : in_head[1];
    assign host_wr_ready = host_wr_sel ? (in_cnt[1] != FULL_CNT) : (in_cnt[0] != FULL_CNT);

    assign in1_count  = in_cnt[0];
    assign in2_count  = in_cnt[1];
    assign out1_count = out_cnt[0];
    assign out2_count = out_cnt[1];

    // Sticky status; a new event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= '0;
            overflow  <= '0;
        end else if (clr_status) begin
            underflow <= uf_set;
            overflow  <= of_set;
        end else begin
            underflow <= underflow | uf_set;
            overflow  <= overflow | of_set;
        end
    end

    // Host read port: one-cycle latency, data holds when nothing was popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            host_rd_valid <= 1'b0;
            host_rd_data  <= '0;
        end else begin
            host_rd_valid <= |out_rd;
            if (|out_rd) host_rd_data <= out_head[host_rd_sel];
        end
    end
endmodule
